// File: rtl/sprite_reg_shadow.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_reg_shadow
//  Description : Avalon-MM register bank for the sprite/score renderer.
//                Host writes land in a shadow copy that is committed to the
//                active copy atomically at vblank entry (or on force-commit),
//                so the renderer never sees a half-updated frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_reg_shadow #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 8,
  parameter int VACTIVE  = 480
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         chipselect,
  input  logic                         write,
  input  logic                         read,
  input  logic [8:0]                   address,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  input  logic [9:0]                   vcount,
  output logic [NUM_REGS*DATA_W-1:0]   active_regs,
  output logic                         commit,
  output logic                         pending,
  output logic [15:0]                  frame_count
);

  localparam int         C_IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] C_ADDR_CTRL  = 9'(NUM_REGS);
  localparam logic [8:0] C_ADDR_FRAME = 9'(NUM_REGS + 1);
  localparam logic [9:0] C_VACTIVE    = 10'(VACTIVE);

  logic [DATA_W-1:0]          r_shadow [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] w_shadow_flat;
  logic                       r_vblank_d;
  logic                       r_freeze;
  logic                       r_force;
  logic                       w_vblank;
  logic                       w_edge;
  logic                       w_data_wr;
  logic                       w_ctrl_wr;
  logic                       w_rd;
  logic                       w_copy;
  logic [C_IDX_W-1:0]         w_idx;
  logic [31:0]                w_rd_mux;
  logic                       w_unused;

  // Upper write-data bits carry nothing for an 8-bit register.
  assign w_unused = ^writedata[31:DATA_W];

  assign w_vblank  = (vcount >= C_VACTIVE);
  assign w_edge    = w_vblank & ~r_vblank_d;
  assign w_data_wr = chipselect & write & (address < C_ADDR_CTRL);
  assign w_ctrl_wr = chipselect & write & (address == C_ADDR_CTRL);
  assign w_rd      = chipselect & read;
  assign w_idx     = address[C_IDX_W-1:0];

  // A pending force request and a vblank commit in the same cycle still
  // produce a single copy; force ignores freeze, the edge path honours it.
  assign w_copy = r_force | (w_edge & pending & ~r_freeze);

  // Flatten the shadow array so it can be copied to active_regs in one go.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pack
    assign w_shadow_flat[gi*DATA_W +: DATA_W] = r_shadow[gi];
  end

  // Readback mux: shadow data, CTRL status, frame counter, else zero.
  always_comb begin
    w_rd_mux = '0;
    if (address < C_ADDR_CTRL) begin
      w_rd_mux[DATA_W-1:0] = r_shadow[w_idx];
    end else if (address == C_ADDR_CTRL) begin
      w_rd_mux[1:0] = {r_freeze, pending};
    end else if (address == C_ADDR_FRAME) begin
      w_rd_mux[15:0] = frame_count;
    end
  end

  // Shadow register file written by the host.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (w_data_wr) begin
      r_shadow[w_idx] <= writedata[DATA_W-1:0];
    end
  end

  // Vblank edge detect, frame counting, shadow->active commit and CTRL state.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_regs <= '0;
      commit      <= 1'b0;
      pending     <= 1'b0;
      frame_count <= '0;
      r_freeze    <= 1'b0;
      r_force     <= 1'b0;
      // Treat reset as "already in vblank" so a reset inside vblank cannot
      // fabricate an edge; the first commit needs a pass through active video.
      r_vblank_d  <= 1'b1;
    end else begin
      r_vblank_d <= w_vblank;
      commit     <= w_copy;
      r_force    <= w_ctrl_wr & writedata[0];
      if (w_ctrl_wr) begin
        r_freeze <= writedata[1];
      end
      if (w_edge) begin
        frame_count <= frame_count + 16'd1;
      end
      if (w_copy) begin
        active_regs <= w_shadow_flat;
      end
      // A write landing in a commit cycle keeps pending set: its value was
      // not part of the copy and must go out at the next commit.
      if (w_data_wr) begin
        pending <= 1'b1;
      end else if (w_copy) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered readback; holds its value between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (w_rd) begin
      readdata <= w_rd_mux;
    end
  end

endmodule
`default_nettype wire
